// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer: default widths,
// the per-output slot state encoding and the routing select encoding.
package demux_pkg;

    localparam int DEMUX_DATA_W = 8;
    localparam int DEMUX_CNT_W  = 16;

    // Holding slot state: EMPTY has no beat, FULL presents a beat downstream.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    // in_sel encoding.
    localparam logic SEL_Y0 = 1'b0;
    localparam logic SEL_Y1 = 1'b1;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry valid/ready holding register feeding one demux output.
//
// Handshake: a beat transfers on a rising edge where out_valid && out_ready.
// out_data is stable while out_valid && !out_ready. can_load says whether a
// load this cycle can be absorbed (slot empty, or being drained this edge),
// so a full slot with a ready consumer still takes one beat per cycle.
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = DEMUX_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              can_load
);

    slot_state_e state;

    // Slot FSM and payload register; a load while draining overwrites in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= '0;
        end else if (load) begin
            state    <= FULL;
            out_data <= load_data;
        end else if (out_ready) begin
            state    <= EMPTY;
        end
    end

    assign out_valid = (state == FULL);
    assign can_load  = (state == EMPTY) || out_ready;

endmodule

// File: rtl/demux_1to2_stream.sv
// Registered 1-to-2 stream demultiplexer. Each input beat is routed by in_sel
// (sampled with the beat) into one of two independent holding slots, so a
// stalled consumer never blocks traffic headed to the other one.
//
// Optional build macro DEMUX_CNT_EN adds cnt0/cnt1: wrapping counts of beats
// delivered on y0/y1, cleared only by rst.
module demux_1to2_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = DEMUX_DATA_W,
    parameter int CNT_W  = DEMUX_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    output logic              y0_valid,
    input  logic              y0_ready,
    output logic [DATA_W-1:0] y0_data,
    output logic              y1_valid,
    input  logic              y1_ready,
    output logic [DATA_W-1:0] y1_data
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
`endif
);

    logic can_load0;
    logic can_load1;
    logic accept;
    logic load0;
    logic load1;

    // in_ready looks only at the selected slot, never at in_valid.
    assign in_ready = !rst && ((in_sel == SEL_Y1) ? can_load1 : can_load0);
    assign accept   = in_valid && in_ready;
    assign load0    = accept && (in_sel == SEL_Y0);
    assign load1    = accept && (in_sel == SEL_Y1);

    demux_out_slot #(.DATA_W(DATA_W)) u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .load      (load0),
        .load_data (in_data),
        .out_valid (y0_valid),
        .out_ready (y0_ready),
        .out_data  (y0_data),
        .can_load  (can_load0)
    );

    demux_out_slot #(.DATA_W(DATA_W)) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .load      (load1),
        .load_data (in_data),
        .out_valid (y1_valid),
        .out_ready (y1_ready),
        .out_data  (y1_data),
        .can_load  (can_load1)
    );

`ifdef DEMUX_CNT_EN
    // Delivered-beat counters, free-running modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (y0_valid && y0_ready) cnt0 <= cnt0 + 1'b1;
            if (y1_valid && y1_ready) cnt1 <= cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Self-checking bench for demux_1to2_stream: directed routing, stall,
// streaming and reset cases, a randomised phase, and (with DEMUX_CNT_EN)
// the counter wrap. A negedge monitor keeps one expected queue per output.
`timescale 1ns/1ps
module tb_demux_1to2_stream;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sel;
    logic              y0_valid;
    logic              y0_ready;
    logic [DATA_W-1:0] y0_data;
    logic              y1_valid;
    logic              y1_ready;
    logic [DATA_W-1:0] y1_data;
`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [DATA_W-1:0] exp0_q[$];
    logic [DATA_W-1:0] exp1_q[$];

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    demux_1to2_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .y0_valid (y0_valid),
        .y0_ready (y0_ready),
        .y0_data  (y0_data),
        .y1_valid (y1_valid),
        .y1_ready (y1_ready),
        .y1_data  (y1_data)
`ifdef DEMUX_CNT_EN
        ,
        .cnt0     (cnt0),
        .cnt1     (cnt1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare deliveries, then record new accepts.
    always @(negedge clk) begin
        if (rst) begin
            exp0_q.delete();
            exp1_q.delete();
        end else begin
            if (y0_valid && y0_ready) begin
                if (exp0_q.size() == 0) check("y0_unexpected_beat", 32'(y0_data), 32'hFFFF_FFFF);
                else check("y0_data", 32'(y0_data), 32'(exp0_q.pop_front()));
            end
            if (y1_valid && y1_ready) begin
                if (exp1_q.size() == 0) check("y1_unexpected_beat", 32'(y1_data), 32'hFFFF_FFFF);
                else check("y1_data", 32'(y1_data), 32'(exp1_q.pop_front()));
            end
            if (in_valid && in_ready) begin
                if (in_sel) exp1_q.push_back(in_data);
                else        exp0_q.push_back(in_data);
            end
        end
    end

    initial begin
        bit acc;
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; in_sel = 1'b0;
        y0_ready = 1'b0; y1_ready = 1'b0;

        // Reset held two cycles with in_valid high
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_in_ready", 32'(in_ready), 0);
            check("rst_y0_valid", 32'(y0_valid), 0);
            check("rst_y1_valid", 32'(y1_valid), 0);
            check("rst_y0_data", 32'(y0_data), 0);
            check("rst_y1_data", 32'(y1_data), 0);
`ifdef DEMUX_CNT_EN
            check("rst_cnt0", 32'(cnt0), 0);
            check("rst_cnt1", 32'(cnt1), 0);
`endif
            step();
        end
        rst = 1'b0; in_valid = 1'b0;
        step();

        // Basic routing, consecutive beats to y0 then y1
        y0_ready = 1'b1; y1_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'hA5; in_sel = 1'b0;
        @(negedge clk);
        check("basic_in_ready", 32'(in_ready), 1);
        step();
        check("basic_y0_valid", 32'(y0_valid), 1);
        check("basic_y0_data", 32'(y0_data), 32'hA5);
        check("basic_y1_idle", 32'(y1_valid), 0);
        in_data = 8'h3C; in_sel = 1'b1;
        step();
        check("basic_y0_one_cycle", 32'(y0_valid), 0);
        check("basic_y1_valid", 32'(y1_valid), 1);
        check("basic_y1_data", 32'(y1_data), 32'h3C);
        in_valid = 1'b0;
        step();
        check("basic_y1_one_cycle", 32'(y1_valid), 0);

        // Independent stall: y0 blocked, y1 traffic keeps flowing
        y0_ready = 1'b0; y1_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h11; in_sel = 1'b0;
        step();
        check("stall_y0_valid", 32'(y0_valid), 1);
        check("stall_y0_data", 32'(y0_data), 32'h11);
        in_data = 8'h22; in_sel = 1'b0;
        @(negedge clk);
        check("stall_in_ready_low", 32'(in_ready), 0);
        step();
        @(negedge clk);
        check("stall_in_ready_still_low", 32'(in_ready), 0);
        check("stall_y0_hold", 32'(y0_data), 32'h11);
        step();
        in_valid = 1'b0;
        step();
        in_valid = 1'b1; in_data = 8'h33; in_sel = 1'b1;
        @(negedge clk);
        check("stall_sel1_ready", 32'(in_ready), 1);
        step();
        check("stall_y1_valid", 32'(y1_valid), 1);
        check("stall_y1_data", 32'(y1_data), 32'h33);
        check("stall_y0_still_11", 32'(y0_data), 32'h11);
        in_data = 8'h22; in_sel = 1'b0; y0_ready = 1'b1;
        @(negedge clk);
        check("stall_release_ready", 32'(in_ready), 1);
        step();
        check("stall_y0_next_valid", 32'(y0_valid), 1);
        check("stall_y0_next_data", 32'(y0_data), 32'h22);
        in_valid = 1'b0;
        step();
        check("stall_y0_drained", 32'(y0_valid), 0);

        // Full-throughput stream of 16 beats to y1
        y1_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 8'(i); in_sel = 1'b1;
            @(negedge clk);
            check("stream_in_ready", 32'(in_ready), 1);
            if (i > 0) begin
                check("stream_y1_valid", 32'(y1_valid), 1);
                check("stream_y1_data", 32'(y1_data), 32'(i - 1));
            end
            step();
        end
        in_valid = 1'b0;
        step();
        step();

        // Mid-operation reset discards buffered beats
        y0_ready = 1'b0; y1_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h55; in_sel = 1'b0;
        step();
        in_data = 8'hAA; in_sel = 1'b1;
        step();
        in_valid = 1'b0;
        check("mid_y0_full", 32'(y0_valid), 1);
        check("mid_y1_full", 32'(y1_valid), 1);
        check("mid_y0_data", 32'(y0_data), 32'h55);
        check("mid_y1_data", 32'(y1_data), 32'hAA);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_y0_cleared", 32'(y0_valid), 0);
        check("mid_y1_cleared", 32'(y1_valid), 0);
        check("mid_y0_data_zero", 32'(y0_data), 0);
        check("mid_y1_data_zero", 32'(y1_data), 0);
        y0_ready = 1'b1; y1_ready = 1'b1;
        repeat (3) step();
        check("mid_y0_no_ghost", 32'(y0_valid), 0);
        check("mid_y1_no_ghost", 32'(y1_valid), 0);

        // Randomised traffic with random consumer stalls
        in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            y0_ready = ($urandom_range(0, 3) != 0);
            y1_ready = ($urandom_range(0, 2) != 0);
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 4) != 0);
                in_data  = 8'($urandom_range(0, 255));
                in_sel   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
        end
        in_valid = 1'b0; y0_ready = 1'b1; y1_ready = 1'b1;
        repeat (4) step();
        check("drain_q0_empty", 32'(exp0_q.size()), 0);
        check("drain_q1_empty", 32'(exp1_q.size()), 0);

`ifdef DEMUX_CNT_EN
        // Counter wrap: 17 beats to y0 on a 4-bit counter
        rst = 1'b1;
        step();
        rst = 1'b0;
        y0_ready = 1'b1; y1_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h80 + i); in_sel = 1'b0;
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();
        check("cnt0_wrap", 32'(cnt0), 1);
        check("cnt1_idle", 32'(cnt1), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
